// File: rtl/sleep_sequencer.sv
// Core sleep sequencer: drains the pipeline, gates the core clock, and wakes on request or timeout.
// Latency: every output is registered and reflects the state entered on the previous rising clk edge.
// Backpressure: mem_busy holds DRAIN indefinitely; WAKE runs to completion and cannot be aborted.
module sleep_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned WAKE_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sleep_request,
    input  logic        wakeup_request,
    input  logic        mem_busy,
    input  logic        timer_en,
    input  logic [15:0] timer_value,
    output logic        clock_enable,
    output logic        fetch_hold,
    output logic        sleep_state,
    output logic        wake_done,
    output logic [1:0]  state_out,
    output logic [15:0] sleep_cycles
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_SLEEP  = 2'b10,
        ST_WAKE   = 2'b11
    } state_e;

    // Counters are loaded with N-1 so that a counter reaching 0 marks the last dwell cycle.
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] WAKE_LOAD  = 8'(WAKE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  drain_cnt_q, drain_cnt_d;
    logic [7:0]  wake_cnt_q, wake_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic        tmr_en_q, tmr_en_d;
    logic [15:0] sleep_cnt_q, sleep_cnt_d;
    logic        wake_done_q, wake_done_d;
    logic        clock_enable_q, clock_enable_d;
    logic        fetch_hold_q, fetch_hold_d;
    logic        sleep_state_q, sleep_state_d;

    // Next-state logic, counter updates and registered-output decode of the next state.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        wake_cnt_d  = wake_cnt_q;
        timer_d     = timer_q;
        tmr_en_d    = tmr_en_q;
        wake_done_d = 1'b0;

        case (state_q)
            ST_ACTIVE: begin
                // Wake wins when both requests are present.
                if (sleep_request && !wakeup_request) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (wakeup_request) begin
                    state_d = ST_ACTIVE;
                end else if (drain_cnt_q == 8'd0 && !mem_busy) begin
                    state_d  = ST_SLEEP;
                    timer_d  = timer_value;
                    tmr_en_d = timer_en;
                end else if (drain_cnt_q != 8'd0) begin
                    drain_cnt_d = drain_cnt_q - 8'd1;
                end
            end
            ST_SLEEP: begin
                if (wakeup_request || (tmr_en_q && timer_q == 16'd0)) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end else if (timer_q != 16'd0) begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == 8'd0) begin
                    state_d     = ST_ACTIVE;
                    wake_done_d = 1'b1;
                end else begin
                    wake_cnt_d = wake_cnt_q - 8'd1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase

        sleep_cnt_d = sleep_cnt_q;
        if (state_q == ST_SLEEP && sleep_cnt_q != 16'hFFFF) begin
            sleep_cnt_d = sleep_cnt_q + 16'd1;
        end

        clock_enable_d = (state_d != ST_SLEEP);
        fetch_hold_d   = (state_d != ST_ACTIVE);
        sleep_state_d  = (state_d == ST_SLEEP);
    end

    // State, counters and output registers; reset re-enables the clock immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_ACTIVE;
            drain_cnt_q    <= 8'd0;
            wake_cnt_q     <= 8'd0;
            timer_q        <= 16'd0;
            tmr_en_q       <= 1'b0;
            sleep_cnt_q    <= 16'd0;
            wake_done_q    <= 1'b0;
            clock_enable_q <= 1'b1;
            fetch_hold_q   <= 1'b0;
            sleep_state_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            wake_cnt_q     <= wake_cnt_d;
            timer_q        <= timer_d;
            tmr_en_q       <= tmr_en_d;
            sleep_cnt_q    <= sleep_cnt_d;
            wake_done_q    <= wake_done_d;
            clock_enable_q <= clock_enable_d;
            fetch_hold_q   <= fetch_hold_d;
            sleep_state_q  <= sleep_state_d;
        end
    end

    assign clock_enable = clock_enable_q;
    assign fetch_hold   = fetch_hold_q;
    assign sleep_state  = sleep_state_q;
    assign wake_done    = wake_done_q;
    assign state_out    = state_q;
    assign sleep_cycles = sleep_cnt_q;

endmodule

// File: tb/tb_sleep_sequencer.sv
// Directed scenarios for sleep_sequencer with a per-cycle expected-output scoreboard.
// Each task queues stimulus steps, pushes the expected outputs as each step is driven, and pops/compares after the edge.
// Checks: reset, drain/sleep/wake flow, mem_busy stall, timed wake, abort, back-to-back request, async reset.
module tb_sleep_sequencer;

    localparam logic [1:0] A = 2'b00;
    localparam logic [1:0] D = 2'b01;
    localparam logic [1:0] S = 2'b10;
    localparam logic [1:0] W = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sleep_request = 1'b0;
    logic        wakeup_request = 1'b0;
    logic        mem_busy = 1'b0;
    logic        timer_en = 1'b0;
    logic [15:0] timer_value = 16'd0;
    logic        clock_enable, fetch_hold, sleep_state, wake_done;
    logic [1:0]  state_out;
    logic [15:0] sleep_cycles;

    typedef struct {
        logic        sreq;
        logic        wreq;
        logic        busy;
        logic        ten;
        logic [15:0] tval;
        logic [1:0]  st;
        logic        wd;
    } step_t;

    step_t      stim_q[$];
    logic [5:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_sleep = 0;

    sleep_sequencer #(.DRAIN_CYCLES(4), .WAKE_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .sleep_request  (sleep_request),
        .wakeup_request (wakeup_request),
        .mem_busy       (mem_busy),
        .timer_en       (timer_en),
        .timer_value    (timer_value),
        .clock_enable   (clock_enable),
        .fetch_hold     (fetch_hold),
        .sleep_state    (sleep_state),
        .wake_done      (wake_done),
        .state_out      (state_out),
        .sleep_cycles   (sleep_cycles)
    );

    always #5 clk = ~clk;

    // Expected {state_out, clock_enable, fetch_hold, sleep_state, wake_done} for a state.
    function automatic logic [5:0] exp_vec(input logic [1:0] st, input logic wd);
        case (st)
            A:       return {st, 3'b100, wd};
            S:       return {st, 3'b011, wd};
            default: return {st, 3'b110, wd};
        endcase
    endfunction

    task automatic add(input logic sreq, input logic wreq, input logic busy, input logic ten,
                       input logic [15:0] tval, input logic [1:0] st, input logic wd, input int n);
        step_t s;
        s.sreq = sreq; s.wreq = wreq; s.busy = busy; s.ten = ten;
        s.tval = tval; s.st = st; s.wd = wd;
        for (int i = 0; i < n; i++) stim_q.push_back(s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({state_out, clock_enable, fetch_hold, sleep_state, wake_done} !== exp_vec(A, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b",
                     {state_out, clock_enable, fetch_hold, sleep_state, wake_done}, exp_vec(A, 1'b0));
        end
        n_checks++;
        if (sleep_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_sleep_cycles: got %0d want 0", sleep_cycles);
        end
        rst = 1'b0;
    endtask

    task automatic test_timer();
        step_t s;
        logic [5:0] e;
        int k = 0;
        // timer_value 5: six SLEEP cycles; timer_value changed during SLEEP must not matter.
        add(1, 0, 0, 1, 16'd5, D, 0, 1);
        add(0, 0, 0, 1, 16'd5, D, 0, 3);
        add(0, 0, 0, 1, 16'd5, S, 0, 1);
        add(0, 0, 0, 1, 16'h0033, S, 0, 5);
        add(0, 0, 0, 0, 16'd0, W, 0, 2);
        add(0, 0, 0, 0, 16'd0, A, 1, 1);
        add(0, 0, 0, 0, 16'd0, A, 0, 1);
        // timer_value 0: a single SLEEP cycle.
        add(1, 0, 0, 1, 16'd0, D, 0, 1);
        add(0, 0, 0, 1, 16'd0, D, 0, 3);
        add(0, 0, 0, 1, 16'd0, S, 0, 1);
        add(0, 0, 0, 0, 16'd0, W, 0, 2);
        add(0, 0, 0, 0, 16'd0, A, 1, 1);
        add(0, 0, 0, 0, 16'd0, A, 0, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            sleep_request = s.sreq; wakeup_request = s.wreq; mem_busy = s.busy;
            timer_en = s.ten; timer_value = s.tval;
            exp_q.push_back(exp_vec(s.st, s.wd));
            if (s.st == S) exp_sleep++;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({state_out, clock_enable, fetch_hold, sleep_state, wake_done} !== e) begin
                n_fail++;
                $display("FAIL timer step %0d: got %b want %b", k,
                         {state_out, clock_enable, fetch_hold, sleep_state, wake_done}, e);
            end
            if (k == 13) begin
                n_checks++;
                if (sleep_cycles !== 16'd6) begin
                    n_fail++;
                    $display("FAIL timer_sleep_cycles_6: got %0d want 6", sleep_cycles);
                end
            end
            k++;
        end
        n_checks++;
        if (sleep_cycles !== 16'(exp_sleep)) begin
            n_fail++;
            $display("FAIL timer_sleep_cycles: got %0d want %0d", sleep_cycles, exp_sleep);
        end
    endtask

    task automatic test_basic();
        step_t s;
        logic [5:0] e;
        int k = 0;
        add(1, 0, 0, 0, 16'd0, D, 0, 1);
        add(0, 0, 0, 0, 16'd0, D, 0, 3);
        add(0, 0, 0, 0, 16'd0, S, 0, 4);
        add(0, 1, 0, 0, 16'd0, W, 0, 1);
        add(0, 0, 0, 0, 16'd0, W, 0, 1);
        add(0, 0, 0, 0, 16'd0, A, 1, 1);
        add(0, 0, 0, 0, 16'd0, A, 0, 2);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            sleep_request = s.sreq; wakeup_request = s.wreq; mem_busy = s.busy;
            timer_en = s.ten; timer_value = s.tval;
            exp_q.push_back(exp_vec(s.st, s.wd));
            if (s.st == S) exp_sleep++;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({state_out, clock_enable, fetch_hold, sleep_state, wake_done} !== e) begin
                n_fail++;
                $display("FAIL basic step %0d: got %b want %b", k,
                         {state_out, clock_enable, fetch_hold, sleep_state, wake_done}, e);
            end
            k++;
        end
        n_checks++;
        if (sleep_cycles !== 16'(exp_sleep)) begin
            n_fail++;
            $display("FAIL basic_sleep_cycles: got %0d want %0d", sleep_cycles, exp_sleep);
        end
    endtask

    task automatic test_mem_busy();
        step_t s;
        logic [5:0] e;
        int k = 0;
        // mem_busy high for the first 10 DRAIN cycles; SLEEP on the edge after it falls.
        add(1, 0, 1, 0, 16'd0, D, 0, 1);
        add(0, 0, 1, 0, 16'd0, D, 0, 10);
        add(0, 0, 0, 0, 16'd0, S, 0, 1);
        add(0, 1, 0, 0, 16'd0, W, 0, 1);
        add(0, 0, 0, 0, 16'd0, W, 0, 1);
        add(0, 0, 0, 0, 16'd0, A, 1, 1);
        add(0, 0, 0, 0, 16'd0, A, 0, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            sleep_request = s.sreq; wakeup_request = s.wreq; mem_busy = s.busy;
            timer_en = s.ten; timer_value = s.tval;
            exp_q.push_back(exp_vec(s.st, s.wd));
            if (s.st == S) exp_sleep++;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({state_out, clock_enable, fetch_hold, sleep_state, wake_done} !== e) begin
                n_fail++;
                $display("FAIL mem_busy step %0d: got %b want %b", k,
                         {state_out, clock_enable, fetch_hold, sleep_state, wake_done}, e);
            end
            k++;
        end
        n_checks++;
        if (sleep_cycles !== 16'(exp_sleep)) begin
            n_fail++;
            $display("FAIL mem_busy_sleep_cycles: got %0d want %0d", sleep_cycles, exp_sleep);
        end
    endtask

    task automatic test_abort();
        step_t s;
        logic [5:0] e;
        int k = 0;
        add(1, 1, 0, 0, 16'd0, A, 0, 2);
        add(1, 0, 0, 0, 16'd0, D, 0, 1);
        add(0, 0, 0, 0, 16'd0, D, 0, 1);
        add(0, 1, 0, 0, 16'd0, A, 0, 1);
        add(0, 0, 0, 0, 16'd0, A, 0, 2);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            sleep_request = s.sreq; wakeup_request = s.wreq; mem_busy = s.busy;
            timer_en = s.ten; timer_value = s.tval;
            exp_q.push_back(exp_vec(s.st, s.wd));
            if (s.st == S) exp_sleep++;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({state_out, clock_enable, fetch_hold, sleep_state, wake_done} !== e) begin
                n_fail++;
                $display("FAIL abort step %0d: got %b want %b", k,
                         {state_out, clock_enable, fetch_hold, sleep_state, wake_done}, e);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        logic [5:0] e;
        int k = 0;
        // sleep_request held throughout; both requests in WAKE must be ignored.
        add(1, 0, 0, 0, 16'd0, D, 0, 4);
        add(1, 0, 0, 0, 16'd0, S, 0, 1);
        add(1, 1, 0, 0, 16'd0, W, 0, 2);
        add(1, 0, 0, 0, 16'd0, A, 1, 1);
        add(1, 0, 0, 0, 16'd0, D, 0, 1);
        add(0, 1, 0, 0, 16'd0, A, 0, 1);
        add(0, 0, 0, 0, 16'd0, A, 0, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            sleep_request = s.sreq; wakeup_request = s.wreq; mem_busy = s.busy;
            timer_en = s.ten; timer_value = s.tval;
            exp_q.push_back(exp_vec(s.st, s.wd));
            if (s.st == S) exp_sleep++;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({state_out, clock_enable, fetch_hold, sleep_state, wake_done} !== e) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %b want %b", k,
                         {state_out, clock_enable, fetch_hold, sleep_state, wake_done}, e);
            end
            k++;
        end
    endtask

    task automatic test_rst_mid_sleep();
        step_t s;
        logic [5:0] e;
        int k = 0;
        add(1, 0, 0, 0, 16'd0, D, 0, 1);
        add(0, 0, 0, 0, 16'd0, D, 0, 3);
        add(0, 0, 0, 0, 16'd0, S, 0, 3);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            sleep_request = s.sreq; wakeup_request = s.wreq; mem_busy = s.busy;
            timer_en = s.ten; timer_value = s.tval;
            exp_q.push_back(exp_vec(s.st, s.wd));
            if (s.st == S) exp_sleep++;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({state_out, clock_enable, fetch_hold, sleep_state, wake_done} !== e) begin
                n_fail++;
                $display("FAIL rst_mid_sleep step %0d: got %b want %b", k,
                         {state_out, clock_enable, fetch_hold, sleep_state, wake_done}, e);
            end
            k++;
        end
        // Assert reset between clock edges and look before any edge arrives.
        #2;
        rst = 1'b1;
        #1;
        exp_sleep = 0;
        n_checks++;
        if ({state_out, clock_enable, fetch_hold, sleep_state, wake_done} !== exp_vec(A, 1'b0)) begin
            n_fail++;
            $display("FAIL async_rst_outputs: got %b want %b",
                     {state_out, clock_enable, fetch_hold, sleep_state, wake_done}, exp_vec(A, 1'b0));
        end
        n_checks++;
        if (sleep_cycles !== 16'(exp_sleep)) begin
            n_fail++;
            $display("FAIL async_rst_sleep_cycles: got %0d want %0d", sleep_cycles, exp_sleep);
        end
        #3;
        rst = 1'b0;
        // The first edge after reset release must act on sleep_request.
        add(1, 0, 0, 0, 16'd0, D, 0, 1);
        add(0, 1, 0, 0, 16'd0, A, 0, 1);
        k = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            sleep_request = s.sreq; wakeup_request = s.wreq; mem_busy = s.busy;
            timer_en = s.ten; timer_value = s.tval;
            exp_q.push_back(exp_vec(s.st, s.wd));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({state_out, clock_enable, fetch_hold, sleep_state, wake_done} !== e) begin
                n_fail++;
                $display("FAIL post_rst step %0d: got %b want %b", k,
                         {state_out, clock_enable, fetch_hold, sleep_state, wake_done}, e);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_basic();
        test_mem_busy();
        test_abort();
        test_back_to_back();
        test_rst_mid_sleep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sleep_sequencer.md
SLEEP_SEQUENCER -- requirements
Module: sleep_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4, meaning the minimum number of fetch-hold cycles before gating (one per downstream pipeline stage); legal range 1..255.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2, meaning the number of clock-running, fetch-held cycles after wake before release; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single ungated system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port sleep_request, input, 1 bit: level request to enter sleep.
REQ-006 SHALL have port wakeup_request, input, 1 bit: level request to wake or abort sleep entry.
REQ-007 SHALL have port mem_busy, input, 1 bit: 1 while a store is pending in the M stage; blocks gating.
REQ-008 SHALL have port timer_en, input, 1 bit: enables the timed-wake mechanism.
REQ-009 SHALL have port timer_value, input, 16 bits: sleep timeout, sampled on SLEEP entry.
REQ-010 SHALL have port clock_enable, output, 1 bit: drives the core clock gater enable.
REQ-011 SHALL have port fetch_hold, output, 1 bit: 1 holds PC and injects bubbles into decode.
REQ-012 SHALL have port sleep_state, output, 1 bit: 1 only in SLEEP.
REQ-013 SHALL have port wake_done, output, 1 bit: one-cycle pulse on WAKE->ACTIVE.
REQ-014 SHALL have port state_out, output, 2 bits: current state encoding.
REQ-015 SHALL have port sleep_cycles, output, 16 bits: count of clk cycles spent in SLEEP.

Function
REQ-016 SHALL implement a four-state FSM: ACTIVE=00, DRAIN=01, SLEEP=10, WAKE=11.
REQ-017 SHALL register all outputs, with no combinational path from any input to any output.
REQ-018 SHALL drive, per state (clock_enable/fetch_hold/sleep_state): ACTIVE 1/0/0; DRAIN 1/1/0; SLEEP 0/1/1; WAKE 1/1/0.
REQ-019 SHALL, in ACTIVE, go to DRAIN when sleep_request=1 and wakeup_request=0, loading an 8-bit drain counter with DRAIN_CYCLES-1; when both requests are 1, wake wins and the FSM stays in ACTIVE.
REQ-020 SHALL, in DRAIN, decrement the drain counter each cycle while nonzero; it holds at 0 otherwise.
REQ-021 SHALL, in DRAIN, go to SLEEP on the edge where drain counter=0 and mem_busy=0; mem_busy=1 extends DRAIN indefinitely, so minimum DRAIN dwell is DRAIN_CYCLES cycles.
REQ-022 SHALL, in DRAIN, abort to ACTIVE when wakeup_request=1, taking priority over the SLEEP transition, with no wake_done pulse.
REQ-023 SHALL, on the DRAIN->SLEEP edge, load a 16-bit timer with timer_value and latch timer_en.
REQ-024 SHALL, in SLEEP, go to WAKE when wakeup_request=1, or when latched timer_en=1 and timer=0; otherwise decrement the timer (no wrap below 0), so timer_value=N yields exactly N+1 SLEEP cycles.
REQ-025 SHALL ignore sleep_request outside ACTIVE.
REQ-026 SHALL, on SLEEP->WAKE, load the wake counter with WAKE_CYCLES-1; in WAKE it decrements, and at 0 the FSM goes to ACTIVE, asserting wake_done for exactly the first ACTIVE cycle.
REQ-027 SHALL make WAKE non-abortable: sleep_request and wakeup_request have no effect in WAKE.
REQ-028 SHALL increment sleep_cycles by 1 for every clk cycle with state=SLEEP, saturating at 0xFFFF; only rst clears it.

Reset
REQ-029 SHALL, on rst=1 asynchronously: set state=ACTIVE, clock_enable=1, fetch_hold=0, sleep_state=0, wake_done=0, state_out=00, sleep_cycles=0, and all counters and the timer-enable latch to 0.
REQ-030 SHALL, on rst asserted mid-DRAIN, mid-SLEEP or mid-WAKE, return immediately to reset values, with the clock re-enabled without waiting for an edge.
REQ-031 SHALL, after rst deasserts, evaluate requests from the first rising edge.

Verification
REQ-032 SHALL be verified by directed test: defaults, sleep_request pulse, mem_busy=0, timer_en=0 -> exactly 4 DRAIN cycles, then SLEEP with clock_enable=0; wakeup_request -> 2 WAKE cycles, then ACTIVE with a 1-cycle wake_done.
REQ-033 SHALL be verified by directed test: mem_busy=1 held for 10 cycles during DRAIN -> the FSM stays in DRAIN for 10 cycles and enters SLEEP on the edge after mem_busy falls.
REQ-034 SHALL be verified by directed test: timer_en=1, timer_value=5, no wakeup -> exactly 6 SLEEP cycles, sleep_cycles=6, then WAKE.
REQ-035 SHALL be verified by directed test: sleep_request and wakeup_request both 1 in ACTIVE -> stays ACTIVE; wakeup_request at DRAIN cycle 2 -> ACTIVE next cycle with wake_done=0.
REQ-036 SHALL be verified by directed test: rst pulsed mid-SLEEP -> clock_enable=1, state_out=00 and sleep_cycles=0 immediately without a clock edge.
REQ-037 SHALL be verified by directed test: sleep_request held through WAKE -> ignored in WAKE, then one cycle in ACTIVE followed by DRAIN.
